bexkat2_fpuseq: RTL and testbench

Sequencer between the bexkat2 control FSM and the multi-cycle FPU datapath. It accepts one FPU operation (fpufunc_t) per start pulse and latches the operands. It holds the FPU pipeline clock-enabled for the function's fixed latency, then captures the result and flags and pulses done. Control parks in its FPU state until done_o, or cancels the operation with abort_i on an exception.

---
 rtl/bexkat2_fpuseq_pkg.sv | 34 +++
 rtl/bexkat2_fpuseq.sv | 136 +++++++++++++
 tb/tb_bexkat2_fpuseq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/bexkat2_fpuseq_pkg.sv
// Shared bexkat2 FPU definitions: operation codes, sequencer states and default latencies.
package bexkat1Def;

    typedef enum logic [2:0] {
        FPU_CVTIS = 3'd0,
        FPU_CVTSI = 3'd1,
        FPU_SQRT  = 3'd2,
        FPU_NEG   = 3'd3,
        FPU_ADD   = 3'd4,
        FPU_SUB   = 3'd5,
        FPU_MUL   = 3'd6,
        FPU_DIV   = 3'd7
    } fpufunc_t;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_RUN  = 2'd1,
        FS_DONE = 2'd2
    } fpuseq_state_t;

    localparam int FPU_FLAG_W = 3;

    function automatic int fpu_latency(fpufunc_t f);
        case (f)
            FPU_CVTIS, FPU_CVTSI: return 6;
            FPU_SQRT:             return 16;
            FPU_NEG:              return 1;
            FPU_ADD, FPU_SUB:     return 7;
            FPU_MUL:              return 5;
            default:              return 14;
        endcase
    endfunction

endpackage

// File: rtl/bexkat2_fpuseq.sv
// Sequencer between the bexkat2 control FSM and the multi-cycle FPU datapath.
// Optional: BEXKAT2_FPUSEQ_NEGFAST_EN resolves FPU_NEG locally in one cycle.
module bexkat2_fpuseq
    import bexkat1Def::*;
#(
    parameter int LAT_CVT  = fpu_latency(FPU_CVTIS),
    parameter int LAT_SQRT = fpu_latency(FPU_SQRT),
    parameter int LAT_NEG  = fpu_latency(FPU_NEG),
    parameter int LAT_ADD  = fpu_latency(FPU_ADD),
    parameter int LAT_MUL  = fpu_latency(FPU_MUL),
    parameter int LAT_DIV  = fpu_latency(FPU_DIV)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [2:0]            func_i,
    input  logic [31:0]           a_i,
    input  logic [31:0]           b_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [31:0]           result_o,
    output logic [FPU_FLAG_W-1:0] flags_o,
    output logic                  fpu_en_o,
    output logic [2:0]            fpu_func_o,
    output logic [31:0]           fpu_a_o,
    output logic [31:0]           fpu_b_o,
    input  logic [31:0]           fpu_result_i,
    input  logic [FPU_FLAG_W-1:0] fpu_flags_i
);

    // The counter is 5 bits wide, so every latency must fit 1..31.
    if (LAT_CVT < 1 || LAT_CVT > 31 || LAT_SQRT < 1 || LAT_SQRT > 31 ||
        LAT_NEG < 1 || LAT_NEG > 31 || LAT_ADD  < 1 || LAT_ADD  > 31 ||
        LAT_MUL < 1 || LAT_MUL > 31 || LAT_DIV  < 1 || LAT_DIV  > 31) begin : g_bad_lat
        $error("bexkat2_fpuseq: latency parameter outside 1..31");
    end

    fpuseq_state_t         state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [2:0]            func_q, func_d;
    logic [31:0]           a_q, a_d, b_q, b_d;
    logic [31:0]           res_q, res_d;
    logic [FPU_FLAG_W-1:0] flg_q, flg_d;
    logic [4:0]            lat_m1;
    logic                  accept;

    always_comb begin
        lat_m1 = 5'd0;
        case (fpufunc_t'(func_i))
            FPU_CVTIS, FPU_CVTSI: lat_m1 = 5'(LAT_CVT - 1);
            FPU_SQRT:             lat_m1 = 5'(LAT_SQRT - 1);
            FPU_NEG:              lat_m1 = 5'(LAT_NEG - 1);
            FPU_ADD, FPU_SUB:     lat_m1 = 5'(LAT_ADD - 1);
            FPU_MUL:              lat_m1 = 5'(LAT_MUL - 1);
            FPU_DIV:              lat_m1 = 5'(LAT_DIV - 1);
            default:              lat_m1 = 5'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        func_d  = func_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        flg_d   = flg_q;
        accept  = start_i && !abort_i;
        case (state_q)
            FS_IDLE, FS_DONE: begin
                state_d = FS_IDLE;
                if (accept) begin
`ifdef BEXKAT2_FPUSEQ_NEGFAST_EN
                    if (fpufunc_t'(func_i) == FPU_NEG) begin
                        state_d = FS_DONE;
                        res_d   = a_i ^ 32'h8000_0000;
                        flg_d   = {(a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'd0),
                                   ~a_i[31],
                                   a_i[30:0] == 31'd0};
                    end else
`endif
                    begin
                        state_d = FS_RUN;
                        cnt_d   = lat_m1;
                        func_d  = func_i;
                        a_d     = a_i;
                        b_d     = b_i;
                    end
                end
            end
            FS_RUN: begin
                if (abort_i) begin
                    state_d = FS_IDLE;
                end else if (cnt_q == 5'd0) begin
                    state_d = FS_DONE;
                    res_d   = fpu_result_i;
                    flg_d   = fpu_flags_i;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FS_IDLE;
            cnt_q   <= 5'd0;
            func_q  <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            res_q   <= 32'd0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            func_q  <= func_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    assign busy_o     = (state_q == FS_RUN);
    assign fpu_en_o   = (state_q == FS_RUN);
    assign done_o     = (state_q == FS_DONE);
    assign result_o   = res_q;
    assign flags_o    = flg_q;
    assign fpu_func_o = func_q;
    assign fpu_a_o    = a_q;
    assign fpu_b_o    = b_q;

endmodule

// File: tb/tb_bexkat2_fpuseq.sv
// Scoreboard bench for bexkat2_fpuseq with a stand-in FPU that only yields a
// valid result in the last enabled cycle of each operation.
module tb_bexkat2_fpuseq;
    import bexkat1Def::*;

`ifdef BEXKAT2_FPUSEQ_NEGFAST_EN
    localparam bit NEGFAST = 1'b1;
`else
    localparam bit NEGFAST = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  func_i = 3'd0;
    logic [31:0] a_i = 32'd0;
    logic [31:0] b_i = 32'd0;
    logic        abort_i = 1'b0;
    logic        busy_o, done_o, fpu_en_o;
    logic [31:0] result_o, fpu_a_o, fpu_b_o;
    logic [2:0]  flags_o, fpu_func_o;
    logic [31:0] fpu_result_i;
    logic [2:0]  fpu_flags_i;

    bexkat2_fpuseq dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .func_i(func_i),
        .a_i(a_i), .b_i(b_i), .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
        .result_o(result_o), .flags_o(flags_o), .fpu_en_o(fpu_en_o),
        .fpu_func_o(fpu_func_o), .fpu_a_o(fpu_a_o), .fpu_b_o(fpu_b_o),
        .fpu_result_i(fpu_result_i), .fpu_flags_i(fpu_flags_i)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [31:0] res;
        logic [2:0]  flg;
        logic [2:0]  func;
    } exp_t;

    exp_t        q[$];
    int          bstart = 1;
    int          bend = 0;
    logic [31:0] last_res = 32'd0;
    logic [2:0]  last_flg = 3'd0;
    logic [2:0]  last_func = 3'd0;
    bit          mon_en = 1'b0;

    function automatic int ref_lat(logic [2:0] f);
        case (f)
            3'd0, 3'd1: return 6;
            3'd2:       return 16;
            3'd3:       return 1;
            3'd4, 3'd5: return 7;
            3'd6:       return 5;
            default:    return 14;
        endcase
    endfunction

    function automatic logic [31:0] fake_res(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        return (a ^ {b[15:0], b[31:16]}) + (32'h0100_0001 * {29'd0, f});
    endfunction

    function automatic logic [2:0] fake_flg(logic [31:0] r);
        return r[2:0] ^ r[31:29];
    endfunction

    function automatic logic [2:0] neg_flags(logic [31:0] a);
        logic nan, neg, zero;
        nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        neg  = !a[31];
        zero = (a[30:0] == 0);
        return {nan, neg, zero};
    endfunction

    // Stand-in FPU: counts enabled cycles and presents the real answer only on the last one.
    int en_cnt;
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       en_cnt <= 0;
        else if (fpu_en_o) en_cnt <= en_cnt + 1;
        else               en_cnt <= 0;
    end
    always_comb begin
        fpu_result_i = 32'hBAD0_0000 | 32'(en_cnt);
        if (en_cnt == ref_lat(fpu_func_o) - 1)
            fpu_result_i = fake_res(fpu_func_o, fpu_a_o, fpu_b_o);
        fpu_flags_i = fake_flg(fpu_result_i);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    exp_t me;
    logic exp_busy;
    always @(negedge clk_i) begin
        if (mon_en) begin
            exp_busy = (cyc >= bstart) && (cyc <= bend);
            chk("busy", {31'd0, busy_o}, {31'd0, exp_busy});
            chk("fpu_en", {31'd0, fpu_en_o}, {31'd0, exp_busy});
            if (q.size() > 0 && q[0].at == cyc) begin
                me = q.pop_front();
                chk("done", {31'd0, done_o}, 32'd1);
                chk("result", result_o, me.res);
                chk("flags", {29'd0, flags_o}, {29'd0, me.flg});
                chk("fpu_func", {29'd0, fpu_func_o}, {29'd0, me.func});
                last_res = me.res;
                last_flg = me.flg;
            end else begin
                chk("no_done", {31'd0, done_o}, 32'd0);
                chk("result_hold", result_o, last_res);
                chk("flags_hold", {29'd0, flags_o}, {29'd0, last_flg});
            end
        end
    end

    task automatic drive(input logic st, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic ab);
        exp_t e;
        bit   in_run;
        int   l;
        start_i = st; func_i = f; a_i = a; b_i = b; abort_i = ab;
        in_run = (cyc >= bstart) && (cyc <= bend);
        if (in_run && ab) begin
            bend = cyc;
            q.delete(q.size() - 1);
        end else if (!in_run && st && !ab) begin
            if (NEGFAST && f == 3'(FPU_NEG)) begin
                e.at = cyc + 1; e.res = a ^ 32'h8000_0000; e.flg = neg_flags(a); e.func = last_func;
            end else begin
                l = ref_lat(f);
                bstart = cyc + 1; bend = cyc + l; last_func = f;
                e.at = cyc + l + 1; e.res = fake_res(f, a, b); e.flg = fake_flg(e.res); e.func = f;
            end
            q.push_back(e);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    endtask

    logic [31:0] ra, rb;
    initial begin
        #2;
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_en", {31'd0, fpu_en_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_a", fpu_a_o, 32'd0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1;
        mon_en = 1'b1;
        idle(2);

        drive(1'b1, 3'(FPU_ADD), 32'h3F80_0000, 32'h4000_0000, 1'b0);
        idle(9);
        drive(1'b1, 3'(FPU_MUL), 32'h4040_0000, 32'h4000_0000, 1'b0);
        idle(5);
        drive(1'b1, 3'(FPU_SUB), 32'h4110_0000, 32'h3F80_0000, 1'b0);
        idle(9);
        drive(1'b1, 3'(FPU_SQRT), 32'h4180_0000, 32'd0, 1'b0);
        idle(3);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        idle(4);
        drive(1'b1, 3'(FPU_DIV), 32'h4120_0000, 32'h4000_0000, 1'b0);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        drive(1'b1, 3'(FPU_ADD), 32'h1111_1111, 32'h2222_2222, 1'b0);
        idle(15);
        drive(1'b1, 3'(FPU_ADD), 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        idle(3);
        drive(1'b1, 3'(FPU_NEG), 32'h3F80_0000, 32'd0, 1'b0);
        idle(4);
        drive(1'b1, 3'(FPU_NEG), 32'h7F80_0001, 32'd0, 1'b0);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        drive(1'b1, 3'(FPU_NEG), 32'h8000_0000, 32'd0, 1'b0);
        idle(4);

        drive(1'b1, 3'(FPU_DIV), 32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b0);
        idle(4);
        #2;
        rst_ni = 1'b0;
        q.delete(); bstart = 1; bend = 0;
        last_res = 32'd0; last_flg = 3'd0; last_func = 3'd0;
        #1;
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("mid_rst_en", {31'd0, fpu_en_o}, 32'd0);
        chk("mid_rst_result", result_o, 32'd0);
        chk("mid_rst_flags", {29'd0, flags_o}, 32'd0);
        chk("mid_rst_func", {29'd0, fpu_func_o}, 32'd0);
        chk("mid_rst_b", fpu_b_o, 32'd0);
        idle(3);
        rst_ni = 1'b1;
        idle(20);

        for (int i = 0; i < 800; i++) begin
            ra = $urandom;
            case ($urandom_range(7))
                0: ra = 32'h0000_0000;
                1: ra = 32'h8000_0000;
                2: ra = 32'h7FC0_0000;
                3: ra = 32'hFF80_0000;
                default: ;
            endcase
            rb = $urandom;
            drive(($urandom_range(99) < 40) ? 1'b1 : 1'b0, 3'($urandom_range(7)), ra, rb,
                  ($urandom_range(99) < 4) ? 1'b1 : 1'b0);
        end
        idle(40);
        chk("drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
